// File: rtl/kbd_io_pkg.sv
// Shared constants for the keyboard/LED/seven-segment I/O block.
package kbd_io_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Active-low hex font, entry 0 in the low byte; dp (bit7) always off.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/kbd_led_seg_io_ps2_frame_rx.sv
// PS/2 receiver: synchronises the pins, shifts in 11-bit frames and
// emits one-cycle byte pulses for frames with good start/stop/odd parity.
module ps2_frame_rx
  import kbd_io_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int unsigned IDLE_W = $clog2(FRAME_TIMEOUT + 1);

  logic [2:0]        clk_sync;
  logic [2:0]        dat_sync;
  logic [3:0]        bit_idx;
  logic [9:0]        shreg;
  logic [IDLE_W-1:0] idle_cnt;
  logic              fall;
  logic              din;
  logic              frame_ok;

  assign fall     = !clk_sync[1] && clk_sync[2];
  assign din      = dat_sync[2];
  // Frame check on the 11th bit: shreg holds start..parity, din is stop.
  assign frame_ok = !shreg[0] && din && (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  // An edge always clears the idle counter, so a completing frame beats a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= 4'd0;
      shreg      <= 10'd0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_idx == 4'd10) begin
          bit_idx <= 4'd0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg[8:1];
          end
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {din, shreg[9:1]};
        end
      end else if (idle_cnt != IDLE_W'(FRAME_TIMEOUT)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else if (bit_idx != 4'd0) begin
        bit_idx <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/kbd_led_seg_io.sv
// Board I/O: rotating LED pattern with switch echo, PS/2 make/break
// decoding with press counting, and key state on seven-segment digits.
module kbd_led_seg_io
  import kbd_io_pkg::*;
#(
  parameter int unsigned LED_PERIOD    = 5000000,
  parameter int unsigned FRAME_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] ledr,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam int unsigned CNT_W = $clog2(LED_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       rot;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             key_down;
  logic [7:0]       cur_code;
  logic [7:0]       press_cnt;
  logic [7:0]       raw;
  logic             brk;

  assign ledr = {rot, sw};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rot <= 8'h01;
    end else if (cnt == CNT_W'(LED_PERIOD - 1)) begin
      cnt <= '0;
      rot <= {rot[6:0], rot[7]};
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  ps2_frame_rx #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  // Make/break decode; typematic repeats of the held key are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down  <= 1'b0;
      cur_code  <= 8'd0;
      press_cnt <= 8'd0;
      raw       <= 8'd0;
      brk       <= 1'b0;
    end else if (byte_valid) begin
      raw <= byte_data;
      if (byte_data == PS2_EXT) begin
        brk <= brk;
      end else if (byte_data == PS2_BREAK) begin
        brk <= 1'b1;
      end else if (brk) begin
        key_down <= 1'b0;
        brk      <= 1'b0;
      end else begin
        if (!key_down || (byte_data != cur_code)) begin
          press_cnt <= press_cnt + 8'd1;
        end
        cur_code <= byte_data;
        key_down <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
      seg4 <= hex_seg(4'h0);
      seg5 <= hex_seg(4'h0);
      seg6 <= hex_seg(4'h0);
      seg7 <= hex_seg(4'h0);
    end else begin
      seg0 <= key_down ? hex_seg(cur_code[3:0]) : SEG_BLANK;
      seg1 <= key_down ? hex_seg(cur_code[7:4]) : SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
      seg4 <= hex_seg(press_cnt[3:0]);
      seg5 <= hex_seg(press_cnt[7:4]);
      seg6 <= hex_seg(raw[3:0]);
      seg7 <= hex_seg(raw[7:4]);
    end
  end

endmodule

// File: tb/tb_kbd_led_seg_io.sv
// Directed bench for kbd_led_seg_io: LED rotation, PS/2 decode and displays.
module tb_kbd_led_seg_io;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] ledr;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_led_seg_io #(
    .LED_PERIOD   (4),
    .FRAME_TIMEOUT(100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ledr    (ledr),
    .seg0    (seg0),
    .seg1    (seg1),
    .seg2    (seg2),
    .seg3    (seg3),
    .seg4    (seg4),
    .seg5    (seg5),
    .seg6    (seg6),
    .seg7    (seg7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame bits LSB first: start, d0..d7, parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    logic par;
    par = par_ok ? ~(^b) : (^b);
    return {stop, par, b, 1'b0};
  endfunction

  // Drives n bits; a complete frame returns 6 clk after its last falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      if (i == 10) repeat (6) @(posedge clk);
      else repeat (10) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b1, 1'b1), 11);
  endtask

  task automatic check_segs(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s4, input logic [7:0] s5,
                            input logic [7:0] s6, input logic [7:0] s7);
    check({tag, ".seg0"}, {8'h00, seg0}, {8'h00, s0});
    check({tag, ".seg1"}, {8'h00, seg1}, {8'h00, s1});
    check({tag, ".seg4"}, {8'h00, seg4}, {8'h00, s4});
    check({tag, ".seg5"}, {8'h00, seg5}, {8'h00, s5});
    check({tag, ".seg6"}, {8'h00, seg6}, {8'h00, s6});
    check({tag, ".seg7"}, {8'h00, seg7}, {8'h00, s7});
  endtask

  initial begin
    rst      = 1'b1;
    sw       = 8'hA5;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ledr", ledr, 16'h01A5);
    check("rst_seg2", {8'h00, seg2}, 16'h00FF);
    check("rst_seg3", {8'h00, seg3}, 16'h00FF);
    check_segs("rst", 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    sw = 8'h3C;
    #1;
    check("sw_echo", ledr, 16'h013C);

    // LED rotation with period 4
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rot_hold", {8'h00, ledr[15:8]}, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    check("rot_step1", {8'h00, ledr[15:8]}, 16'h0002);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rot_step2", {8'h00, ledr[15:8]}, 16'h0004);
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("rot_wrap", {8'h00, ledr[15:8]}, 16'h0001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("rot_run", {8'h00, ledr[15:8]}, 16'h0004);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rot_rst", {8'h00, ledr[15:8]}, 16'h0001);
    rst = 1'b0;

    // First key press 0x1C
    send_byte(8'h1C);
    check_segs("make1c", 8'hC6, 8'hF9, 8'hF9, 8'hC0, 8'hC6, 8'hF9);
    send_byte(8'h1C);
    check_segs("repeat1c", 8'hC6, 8'hF9, 8'hF9, 8'hC0, 8'hC6, 8'hF9);
    send_byte(8'hF0);
    check("brk_raw", {8'h00, seg6}, 16'h00C6 ^ 16'h00C6 ^ 16'h00C0);
    check("brk_raw_hi", {8'h00, seg7}, 16'h008E);
    send_byte(8'h1C);
    check_segs("break1c", 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC6, 8'hF9);
    send_byte(8'h32);
    check_segs("make32", 8'hA4, 8'hB0, 8'hA4, 8'hC0, 8'hA4, 8'hB0);

    // Bad frames leave everything unchanged
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    check_segs("badpar", 8'hA4, 8'hB0, 8'hA4, 8'hC0, 8'hA4, 8'hB0);
    send_bits(mk_frame(8'h45, 1'b1, 1'b0), 11);
    check_segs("badstop", 8'hA4, 8'hB0, 8'hA4, 8'hC0, 8'hA4, 8'hB0);

    // Partial frame discarded by the idle timeout
    send_bits(mk_frame(8'hFF, 1'b1, 1'b1), 5);
    repeat (150) @(posedge clk);
    @(negedge clk);
    send_byte(8'h45);
    check_segs("timeout45", 8'h92, 8'h99, 8'hB0, 8'hC0, 8'h92, 8'h99);

    // Reset mid-frame drops the partial bits and clears the decoder
    send_bits(mk_frame(8'hFF, 1'b1, 1'b1), 4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h1C);
    check_segs("rstmid1c", 8'hC6, 8'hF9, 8'hF9, 8'hC0, 8'hC6, 8'hF9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/kbd_led_seg_io.md
Name: kbd_led_seg_io

Overview:
- Board-level I/O block. It drives 16 LEDs: a rotating one-hot pattern plus a switch echo.
- It receives PS/2 keyboard frames, decodes make/break codes and tracks key-press count.
- It shows key state on eight active-low seven-segment digits.
- It sits beside the VGA path in the top level and is driven only by board pins.

Parameters:
- LED_PERIOD, 5000000: clk cycles between LED rotation steps (>=2).
- FRAME_TIMEOUT, 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- sw  in  8  slide switches
- ps2_clk  in  1  PS/2 clock, asynchronous
- ps2_data  in  1  PS/2 data, asynchronous
- ledr  out  16  LEDs
- seg0..seg7  out  8 each  seven-segment digits, active-low; bit0=a … bit6=g, bit7=dp (dp always 1/off)

Behaviour:
- LEDs:
  - ledr[7:0] = sw, combinational.
  - ledr[15:8] = rot register, reset 8'h01.
  - Counter cnt resets to 0 and counts 0..LED_PERIOD-1, then wraps to 0.
  - When cnt==LED_PERIOD-1, rot <= {rot[6:0],rot[7]}.
- PS/2 sync:
  - ps2_clk and ps2_data each pass through a 3-flop synchroniser.
  - Falling edge = stage2==0 && stage3==1; data is sampled from stage3 data at that cycle.
- Framing:
  - 4-bit bit index, reset 0; each falling edge stores one bit, LSB first.
  - Frame bits: start, d0..d7, parity, stop.
  - On the 11th bit the frame is valid iff start==0, stop==1 and XOR(d7..d0,parity)==1 (odd parity).
  - A valid frame emits the byte for one cycle. An invalid frame is dropped silently. The index returns to 0 either way.
- Timeout: idle counter reset on every falling edge. If it reaches FRAME_TIMEOUT with index!=0, index <= 0.
- Decode (state regs reset: key_down=0, cur_code=0, press_cnt=0, raw=0, brk=0):
  - Every valid byte: raw <= byte.
  - 8'hE0: no other effect.
  - 8'hF0: brk <= 1.
  - Any other byte with brk==1: key_down <= 0, brk <= 0.
  - Any other byte with brk==0:
    - If !key_down or byte!=cur_code: press_cnt <= press_cnt+1 (mod 256).
    - Then cur_code <= byte, key_down <= 1.
    - Typematic repeats of the held code do not count.
- Displays (all registered, updated one clk after state changes):
  - seg0/seg1 = cur_code low/high nibble when key_down, else 8'hFF.
  - seg2/seg3 = 8'hFF always.
  - seg4/seg5 = press_cnt low/high nibble.
  - seg6/seg7 = raw low/high nibble.
- Hex font, values 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Reset values: ledr[15:8]=01; seg0-3=FF; seg4-7=C0.
- Latency: state is visible on the seg outputs no later than 6 clk after the 11th ps2_clk falling edge at the pin.
- Simultaneous events: a valid byte and a timeout in the same cycle → the byte wins (the edge cleared the idle counter).
- Reset mid-frame discards the partial frame.

Decomposition:
- Package kbd_io_pkg holds:
  - SEG_BLANK = 8'hFF
  - 16-entry hex-to-segment constant table
  - PS2_BREAK = 8'hF0
  - PS2_EXT = 8'hE0
- One sub-module, ps2_frame_rx: synchroniser, edge detect, 11-bit shift, parity/timeout check.
  - Outputs: byte_valid pulse and byte_data[7:0].
- LED rotator, decoder and display logic stay in the top of the block.

Test Plan:
- Reset with sw=8'hA5: ledr=16'h01A5; seg0-3=FF; seg4-7=C0; sw→8'h3C gives ledr[7:0]=3C the same cycle.
- LED_PERIOD=4:
  - rot steps 01→02→04 every 4 clk.
  - Returns to 01 after 32 clk.
  - rst mid-run restores 01 next clk.
- Frame 0x1C (correct odd parity, ps2_clk period ≥20 clk) → seg0=C6, seg1=F9, seg4=F9, seg5=C0, seg6=C6, seg7=F9.
- Send 1C, 1C, F0, 1C:
  - press count stays 01 (seg4=F9).
  - After the final byte seg0/seg1=FF and seg6/7 still show 1C.
  - Then 0x32 → count 02 (seg4=A4), seg0=A4, seg1=B0.
- Frame 0x1C with wrong parity, and a frame with stop=0 → no output change.
- FRAME_TIMEOUT=100: send 5 bits, idle 150 clk, then a full valid 0x45 frame → seg0=92, seg1=99, count incremented.
